// File: rtl/mac4_sched_pkg.sv
// Shared types and slot-packing helpers for the 4-node MAC array sequencer.
package mac4_sched_pkg;

  localparam int NODES_PER_GROUP = 4;
  localparam int FEATS_PER_NODE  = 4;

  typedef enum logic [2:0] {
    IDLE, FETCH, LAUNCH, WAIT, WRITE, NEXT, DONE
  } state_t;

  // LSB of node slot `slot` in a packed group bus whose elements are `width` bits.
  function automatic int slot_lsb(input int slot, input int width);
    return slot * FEATS_PER_NODE * width;
  endfunction

endpackage

// File: rtl/mac4_sched.sv
// Walks the feature memory four nodes at a time: fetch rows, launch the MAC
// array, capture its 16 results and stream them out one node per beat.
module mac4_sched
  import mac4_sched_pkg::*;
#(
  parameter int IN_SIZE   = 7,
  parameter int OUT_SIZE  = 13,
  parameter int MAX_NODES = 64,
  parameter int ADDR_W    = 6
) (
  input  logic                                                clk,
  input  logic                                                rst_n,
  input  logic                                                start,
  input  logic [ADDR_W:0]                                     cfg_num_nodes,
  output logic                                                busy,
  output logic                                                done,
  output logic                                                feat_rd_en,
  output logic [ADDR_W-1:0]                                   feat_rd_addr,
  input  logic [FEATS_PER_NODE*IN_SIZE-1:0]                   feat_rd_data,
  output logic [NODES_PER_GROUP*FEATS_PER_NODE*IN_SIZE-1:0]   mac_x,
  output logic                                                mac_in_ready,
  input  logic                                                mac_ready,
  input  logic [NODES_PER_GROUP*FEATS_PER_NODE*OUT_SIZE-1:0]  mac_out,
  output logic                                                out_wr_en,
  input  logic                                                out_wr_ready,
  output logic [ADDR_W-1:0]                                   out_wr_addr,
  output logic [FEATS_PER_NODE*OUT_SIZE-1:0]                  out_wr_data
);

  localparam int XW = NODES_PER_GROUP * FEATS_PER_NODE * IN_SIZE;
  localparam int OW = NODES_PER_GROUP * FEATS_PER_NODE * OUT_SIZE;
  localparam int RW = FEATS_PER_NODE * IN_SIZE;
  localparam int WW = FEATS_PER_NODE * OUT_SIZE;
  localparam logic [ADDR_W:0] MAX_N  = (ADDR_W+1)'(MAX_NODES);
  localparam logic [ADDR_W:0] GRP_N  = (ADDR_W+1)'(NODES_PER_GROUP);
  localparam logic [2:0]      S_LAST = 3'(NODES_PER_GROUP);
  localparam logic [1:0]      B_LAST = 2'(NODES_PER_GROUP-1);

  state_t          state_q, state_d;
  logic [ADDR_W:0] num_q, num_d, base_q, base_d;
  logic [2:0]      s_q, s_d;
  logic [1:0]      b_q, b_d;
  logic            rd_vld_q;
  logic [XW-1:0]   mac_x_q, mac_x_d;
  logic [OW-1:0]   cap_q, cap_d;

  logic [ADDR_W:0] rd_idx, wr_idx, cfg_n;
  logic [1:0]      wslot;
  logic            rd_en, wr_en, last_beat;

  assign rd_idx    = base_q + (ADDR_W+1)'(s_q);
  assign wr_idx    = base_q + (ADDR_W+1)'(b_q);
  assign wslot     = 2'(s_q - 3'd1);
  assign cfg_n     = (cfg_num_nodes > MAX_N) ? MAX_N : cfg_num_nodes;
  assign rd_en     = (state_q == FETCH) && (s_q < S_LAST) && (rd_idx < num_q);
  assign wr_en     = (state_q == WRITE);
  // Valid nodes form a prefix of the group, so the first invalid slot ends it.
  assign last_beat = (b_q == B_LAST) || ((wr_idx + (ADDR_W+1)'(1)) >= num_q);

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    base_d  = base_q;
    s_d     = s_q;
    b_d     = b_q;
    mac_x_d = mac_x_q;
    cap_d   = cap_q;
    case (state_q)
      IDLE: if (start) begin
        num_d   = cfg_n;
        base_d  = '0;
        s_d     = '0;
        b_d     = '0;
        state_d = (cfg_n == '0) ? DONE : FETCH;
      end
      FETCH: begin
        // Read data lands one cycle late; slots with no read are zero-filled.
        if (s_q != 3'd0)
          mac_x_d[slot_lsb(int'(wslot), IN_SIZE) +: RW] = rd_vld_q ? feat_rd_data : '0;
        if (s_q == S_LAST) begin
          s_d     = '0;
          state_d = LAUNCH;
        end else begin
          s_d = s_q + 3'd1;
        end
      end
      LAUNCH: state_d = WAIT;
      WAIT: if (mac_ready) begin
        cap_d   = mac_out;
        b_d     = '0;
        state_d = WRITE;
      end
      WRITE: if (out_wr_ready) begin
        if (last_beat) state_d = NEXT;
        else           b_d     = b_q + 2'd1;
      end
      NEXT: begin
        base_d  = base_q + GRP_N;
        state_d = ((base_q + GRP_N) >= num_q) ? DONE : FETCH;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      num_q    <= '0;
      base_q   <= '0;
      s_q      <= '0;
      b_q      <= '0;
      rd_vld_q <= 1'b0;
      mac_x_q  <= '0;
      cap_q    <= '0;
    end else begin
      state_q  <= state_d;
      num_q    <= num_d;
      base_q   <= base_d;
      s_q      <= s_d;
      b_q      <= b_d;
      rd_vld_q <= rd_en;
      mac_x_q  <= mac_x_d;
      cap_q    <= cap_d;
    end
  end

  assign busy         = rst_n && ((state_q == IDLE && start) ||
                                  (state_q != IDLE && state_q != DONE));
  assign done         = (state_q == DONE);
  assign feat_rd_en   = rd_en;
  assign feat_rd_addr = rd_en ? rd_idx[ADDR_W-1:0] : '0;
  assign mac_x        = mac_x_q;
  assign mac_in_ready = (state_q == LAUNCH);
  assign out_wr_en    = wr_en;
  assign out_wr_addr  = wr_en ? wr_idx[ADDR_W-1:0] : '0;
  assign out_wr_data  = wr_en ? cap_q[slot_lsb(int'(b_q), OUT_SIZE) +: WW] : '0;

endmodule
